axi_rd_chk: RTL
===============

# axi_rd_chk

AXI4 read-response checker that sits directly downstream of the NoC slave port's R channel, beside the `axi_nttw_m` traffic generator. It snoops AR handshakes into an outstanding-burst FIFO and accepts R beats, driving `rready`. Each beat is compared against the address-derived pattern that the generator writes. It reports beat, burst and error counters, a sticky error flag, and optional first-error capture, to be observed on the heartbeat LEDs and in the ILA.

## Interface
- `DATA_W`, 128: R data width; multiple of 64.
- `OSTD_DEPTH`, 4: outstanding-burst FIFO depth; power of two, ≥2.
- `CNT_W`, 32: width of the beat, burst and error counters.
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of counters and error state.
- `arvalid` in 1: AR snoop input, valid.
- `arready` in 1: AR snoop input, ready.
- `araddr` in 64: AR snoop input, burst start address.
- `arlen` in 8: AR snoop input, burst length minus one.
- `arid` in 2: AR snoop input, transaction ID.
- `ar_stall` out 1: outstanding FIFO is full; the master must hold `arvalid` low.
- `rvalid` in 1: R channel from the NoC, valid.
- `rready` out 1: R channel ready, driven by this block.
- `rdata` in DATA_W: R channel data.
- `rid` in 2: R channel ID.
- `rlast` in 1: R channel last-beat flag.
- `rresp` in 2: R channel response.
- `busy` out 1: FIFO is non-empty.
- `err` out 1: sticky, any error seen.
- `ovf` out 1: sticky, descriptor dropped because the FIFO was full.
- `err_type` out 4: sticky error flags.
  - bit0: data mismatch.
  - bit1: `rresp` ≠ OKAY.
  - bit2: `rid` mismatch.
  - bit3: `rlast` mismatch.
- `beat_cnt` out CNT_W: number of checked beats.
- `burst_cnt` out CNT_W: number of completed bursts.
- `err_cnt` out CNT_W: number of erroneous beats.
- `err_addr` out 64: address of the first erroneous beat.

## Operation
- **AR capture:** every AR handshake (`arvalid & arready`) pushes {`araddr`, `arlen`, `arid`} into the FIFO.
  - If the FIFO is full and there is no pop in the same cycle, the descriptor is dropped and `ovf` is set.
  - If the FIFO is full and a pop occurs in the same cycle, both the push and the pop succeed.
- **Handshake:** `rready = busy`. R beats are never accepted while the FIFO is empty.
- **Beat address:** `beat_addr = head.araddr + beat_idx*(DATA_W/8)`, computed modulo 2^64. `beat_idx` is a burst-local counter, cleared on pop. Only INCR bursts are checked.
- **Expected data:** 64-bit lane k equals `beat_addr + 8*k` (mod 2^64), with lane 0 in the LSBs. `axi_nttw_m` writes the same pattern.
- **Per-beat checks (on R handshake):**
  - data equals the expected pattern;
  - `rresp` == 2'b00;
  - `rid` == `head.arid`;
  - `rlast` == (`beat_idx == head.arlen`).
- **Pop:** when `beat_idx == head.arlen`, the FIFO pops regardless of `rlast`. An early `rlast` does not pop.
- **Counting:**
  - A beat with any failed check increments `err_cnt` once and ORs the failure bits into `err_type`.
  - `err_cnt` saturates at all-ones.
  - `beat_cnt` and `burst_cnt` wrap.
- **Clear:** `clr` zeroes the counters, `err`, `ovf`, `err_type` and `err_addr`. It does not flush the FIFO or reset `beat_idx`. If `clr` coincides with an update, `clr` wins.
- **Reset:** `aresetn` low asynchronously empties the FIFO and zeroes every register. An in-flight burst is abandoned.

## Timing
- **Reset values:** every output is 0, including `rready`, `ar_stall` and `busy`.
- **Output registration:** `rready`, `busy` and `ar_stall` are derived only from registered FIFO pointers; there is no combinational path from any input.
- **AR to R:** a pushed descriptor makes `rready` high on the next cycle. The earliest accepted R beat is therefore one cycle after the AR handshake.
- **Throughput:** one beat per cycle.
  - Back-to-back bursts incur no bubble: a pop and the next head become valid in the same cycle.
  - `rready` stays high if the FIFO remains non-empty.
- **Status latency:** counters, flags and `err_addr` update on the clock edge that ends the handshake cycle, i.e. one cycle of latency.
- **Compare path:** the data compare is a single-cycle combinational path.

## Configuration
- `RCHK_ERR_CAPTURE_EN` defined: `err_addr` latches the `beat_addr` of the first erroneous beat after reset or `clr`. Later errors do not overwrite it.
- `RCHK_ERR_CAPTURE_EN` undefined: `err_addr` is tied to 0 and no capture register is built.

## Test plan
1. **Clean burst:** AR with addr 0x1000, len 3, id 1, then 4 correct beats with `rlast` on beat 3.
   - Expect `beat_cnt`=4, `burst_cnt`=1, `err`=0, `busy`=0 afterwards.
2. **Data corruption:** as scenario 1, with beat 2 lane 0 XOR 1.
   - Expect `err_cnt`=1, `err_type`=4'b0001.
   - With `RCHK_ERR_CAPTURE_EN`: `err_addr`=0x1020 (DATA_W=128).
3. **Protocol errors:**
   - Beat with `rresp`=SLVERR and wrong `rid` → `err_type`=4'b0110, `err_cnt`=1.
   - Missing `rlast` on the final beat → bit3 set; the burst still pops.
4. **Full FIFO:** 4 ARs with no R traffic → `ar_stall`=1.
   - 5th AR forced anyway → `ovf`=1, `busy`=1.
   - 5th AR coinciding with the final beat of the head burst → accepted, `ovf` stays 0.
5. **Back-to-back bursts:** two bursts, len 0 and len 7, each starting at addr 0xFFFF_FFFF_FFFF_FFF0.
   - `rready` stays high throughout; 9 beats in 9 cycles.
   - Address wraps at 2^64; no errors.
6. **Reset and clear:**
   - `aresetn` asserted mid-burst (beat 2 of 4) → all outputs 0 immediately.
   - A new burst after release checks clean.
   - `clr` held with an erroneous beat → counters remain 0.

Source files
------------

// File: rtl/axi_rd_chk_if.sv
// AR snoop + R channel bundle seen by the read-response checker.
// slave = the checker, master = the traffic side driving AR/R.
interface axi_rd_chk_if #(
  parameter int DATA_W = 128
);
  logic              arvalid;
  logic              arready;
  logic [63:0]       araddr;
  logic [7:0]        arlen;
  logic [1:0]        arid;
  logic              ar_stall;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rid;
  logic              rlast;
  logic [1:0]        rresp;

  modport master (
    output arvalid, arready, araddr, arlen, arid,
    output rvalid, rdata, rid, rlast, rresp,
    input  ar_stall, rready
  );

  modport slave (
    input  arvalid, arready, araddr, arlen, arid,
    input  rvalid, rdata, rid, rlast, rresp,
    output ar_stall, rready
  );
endinterface

// File: rtl/axi_rd_chk.sv
// AXI4 read-response checker: snoops AR into an outstanding FIFO, checks R beats
// against the address pattern. Optional first-error capture: RCHK_ERR_CAPTURE_EN.

// One 64-bit lane of the pattern compare: lane k must equal beat_addr + 8*k.
module axi_rd_chk_lane #(
  parameter int LANE = 0
) (
  input  logic [63:0] beat_addr,
  input  logic [63:0] data,
  output logic        mis
);
  logic [63:0] exp_data;
  assign exp_data = beat_addr + 64'(LANE * 8);
  assign mis      = (data != exp_data);
endmodule

module axi_rd_chk #(
  parameter int DATA_W     = 128,
  parameter int OSTD_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clr,
  axi_rd_chk_if.slave       bus,
  output logic              busy,
  output logic              err,
  output logic              ovf,
  output logic [3:0]        err_type,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [63:0]       err_addr
);
  localparam int              NUM_LANES = DATA_W / 64;
  localparam int              AW        = $clog2(OSTD_DEPTH);
  localparam logic [63:0]     BYTES     = 64'(DATA_W / 8);
  localparam logic [AW:0]     PTR_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  id;
  } desc_t;

  desc_t        mem [OSTD_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty;
  desc_t        head;
  logic [7:0]   beat_idx;

  logic         ar_hs, r_hs, last_beat, push, pop, drop;
  logic [63:0]  beat_addr;
  logic [3:0]   chk_bits;
  logic         beat_err;

  logic [NUM_LANES-1:0][63:0] rdata_l;
  logic [NUM_LANES-1:0]       lane_mis;

  // Status outputs come straight off the registered pointers.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy         = ~empty;
  assign bus.rready   = ~empty;
  assign bus.ar_stall = full;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign ar_hs     = bus.arvalid & bus.arready;
  assign r_hs      = bus.rvalid & ~empty;
  assign last_beat = (beat_idx == head.len);
  assign pop       = r_hs & last_beat;
  // A full FIFO still takes the descriptor when the head retires this cycle.
  assign push      = ar_hs & (~full | pop);
  assign drop      = ar_hs & full & ~pop;

  assign beat_addr = head.addr + 64'(beat_idx) * BYTES;
  assign rdata_l   = bus.rdata;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    axi_rd_chk_lane #(.LANE(k)) u_lane (
      .beat_addr (beat_addr),
      .data      (rdata_l[k]),
      .mis       (lane_mis[k])
    );
  end

  assign chk_bits = {bus.rlast != last_beat,
                     bus.rid   != head.id,
                     bus.rresp != 2'b00,
                     |lane_mis};
  assign beat_err = r_hs & (|chk_bits);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_idx <= '0;
      for (int i = 0; i < OSTD_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= '{addr: bus.araddr, len: bus.arlen, id: bus.arid};
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      // Burst position is tied to the FIFO head, so clr leaves it alone.
      if (r_hs) beat_idx <= pop ? 8'd0 : beat_idx + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      err_cnt   <= '0;
      err_type  <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      err_cnt   <= '0;
      err_type  <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (r_hs) beat_cnt  <= beat_cnt + CNT_ONE;
      if (pop)  burst_cnt <= burst_cnt + CNT_ONE;
      if (beat_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
        err_type <= err_type | chk_bits;
      end
      if (beat_err | drop) err <= 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef RCHK_ERR_CAPTURE_EN
  logic        cap_done;
  logic [63:0] cap_addr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cap_done <= 1'b0;
      cap_addr <= '0;
    end else if (clr) begin
      cap_done <= 1'b0;
      cap_addr <= '0;
    end else if (beat_err && !cap_done) begin
      cap_done <= 1'b1;
      cap_addr <= beat_addr;
    end
  end

  assign err_addr = cap_addr;
`else
  assign err_addr = '0;
`endif

endmodule
